// File: rtl/if_id_queue.sv
// IF/ID fetch-packet queue: DEPTH entries of {pc, ISSUE_W instructions, lane valids}, with partial issue from the head.
// Optional `define IFID_BYPASS_EN: an empty queue forwards the incoming packet to id_* in the same cycle.
module if_id_queue #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4,
    parameter logic [INST_W-1:0] NOP_PAD = 32'h40200000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           if_valid,
    output logic                           if_ready,
    input  logic [ADDR_W-1:0]              if_pc,
    input  logic [ISSUE_W*INST_W-1:0]      if_inst,
    input  logic [ISSUE_W-1:0]             if_lane_vld,
    output logic                           id_valid,
    output logic [ADDR_W-1:0]              id_pc,
    output logic [ISSUE_W*INST_W-1:0]      id_inst,
    output logic [ISSUE_W-1:0]             id_lane_vld,
    input  logic [$clog2(ISSUE_W+1)-1:0]   id_issue_cnt,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
    localparam int PKT_W = ISSUE_W * INST_W;
    localparam int CNT_W = $clog2(ISSUE_W + 1);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [PKT_W-1:0]   inst_mem [DEPTH];
    logic [ISSUE_W-1:0] vld_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [OCC_W-1:0] occ_reg;

    logic [ADDR_W-1:0]  comp_pc, cur_pc, sh_pc;
    logic [PKT_W-1:0]   comp_inst, cur_inst, sh_inst;
    logic [ISSUE_W-1:0] comp_vld, cur_vld, sh_vld;
    logic [CNT_W-1:0]   cur_cnt;
    logic bypass_act, cons_pop, cons_shift, accept, push_wr, head_pop, head_shift;

    // Compact the incoming valid lanes down to lane 0; PC follows the first valid lane.
    always_comb begin
        int pre;
        comp_inst = {ISSUE_W{NOP_PAD}};
        comp_vld  = '0;
        comp_pc   = if_pc;
        pre       = 0;
        for (int i = ISSUE_W - 1; i >= 0; i--) begin
            if (if_lane_vld[i]) comp_pc = if_pc + ADDR_W'(4 * i);
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (if_lane_vld[i] && pre == k) begin
                    comp_inst[k*INST_W +: INST_W] = if_inst[i*INST_W +: INST_W];
                    comp_vld[k] = 1'b1;
                end
            end
            pre = pre + (if_lane_vld[i] ? 1 : 0);
        end
    end

`ifdef IFID_BYPASS_EN
    assign bypass_act = (occ_reg == '0) && !flush && if_valid;
`else
    assign bypass_act = 1'b0;
`endif

    assign cur_pc   = bypass_act ? comp_pc   : pc_mem[rd_ptr_reg];
    assign cur_inst = bypass_act ? comp_inst : inst_mem[rd_ptr_reg];
    assign cur_vld  = bypass_act ? comp_vld  : vld_mem[rd_ptr_reg];

    assign id_valid    = (occ_reg != '0) || bypass_act;
    assign id_pc       = id_valid ? cur_pc   : '0;
    assign id_inst     = id_valid ? cur_inst : '0;
    assign id_lane_vld = id_valid ? cur_vld  : '0;
    assign if_ready    = (occ_reg < OCC_W'(DEPTH));
    assign occupancy   = occ_reg;

    // Remainder of a partially issued packet: shift down by n, pad the top, advance the PC.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < ISSUE_W; i++) cur_cnt = cur_cnt + CNT_W'(cur_vld[i]);
        sh_inst = {ISSUE_W{NOP_PAD}};
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                if (j == k + int'(id_issue_cnt)) sh_inst[k*INST_W +: INST_W] = cur_inst[j*INST_W +: INST_W];
            end
        end
        sh_vld = cur_vld >> id_issue_cnt;
        sh_pc  = cur_pc + (ADDR_W'(id_issue_cnt) << 2);
    end

    assign cons_pop   = id_valid && (id_issue_cnt != '0) && (id_issue_cnt >= cur_cnt);
    assign cons_shift = id_valid && (id_issue_cnt != '0) && (id_issue_cnt <  cur_cnt);
    assign accept     = if_valid && if_ready && !flush && (if_lane_vld != '0);
    assign push_wr    = accept && !(bypass_act && cons_pop);
    assign head_pop   = !flush && !bypass_act && cons_pop;
    assign head_shift = !flush && !bypass_act && cons_shift;

    // Push and head rewrite never collide: a push needs a free slot, a rewrite needs a held one.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            pc_mem[wr_ptr_reg]   <= (bypass_act && cons_shift) ? sh_pc   : comp_pc;
            inst_mem[wr_ptr_reg] <= (bypass_act && cons_shift) ? sh_inst : comp_inst;
            vld_mem[wr_ptr_reg]  <= (bypass_act && cons_shift) ? sh_vld  : comp_vld;
        end
        if (head_shift) begin
            pc_mem[rd_ptr_reg]   <= sh_pc;
            inst_mem[rd_ptr_reg] <= sh_inst;
            vld_mem[rd_ptr_reg]  <= sh_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_wr)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (head_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            occ_reg <= occ_reg + OCC_W'(push_wr) - OCC_W'(head_pop);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: expected head packets go into a scoreboard, a negedge monitor checks each consume.
module tb_if_id_queue;
    localparam logic [31:0] NOP = 32'h40200000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [63:0] if_inst = '0;
    logic [1:0]  if_lane_vld = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [63:0] id_inst;
    logic [1:0]  id_lane_vld;
    logic [1:0]  id_issue_cnt = '0;
    logic [2:0]  occupancy;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  vld;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    if_id_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_inst(if_inst), .if_lane_vld(if_lane_vld),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_lane_vld(id_lane_vld), .id_issue_cnt(id_issue_cnt),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                         input logic [1:0] lv, input logic [1:0] cnt);
        if_valid = v; if_pc = pc; if_inst = inst; if_lane_vld = lv; id_issue_cnt = cnt;
    endtask

    task automatic expect_head(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] vld);
        exp_t e;
        e.pc = pc; e.inst = inst; e.vld = vld;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle in which decode consumes, the presented head must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && !flush && id_valid && id_issue_cnt != 2'd0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL consume_unexpected: got pc %h, expected no packet", id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("head_pc", 64'(id_pc), 64'(e.pc));
                chk("head_inst", id_inst, e.inst);
                chk("head_vld", 64'(id_lane_vld), 64'(e.vld));
                $display("consume pc=%h inst=%h vld=%b", id_pc, id_inst, id_lane_vld);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_pc", 64'(id_pc), 64'd0);
        chk("rst_id_inst", id_inst, 64'd0);
        chk("rst_id_vld", 64'(id_lane_vld), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);

        // Single push, full issue; cnt is ignored while the queue is empty
        step();
        drive(1, 32'h100, {32'hBBBB0001, 32'hAAAA0001}, 2'b11, 2'd2);
        @(negedge clk);
        chk("lat_id_valid", 64'(id_valid), 64'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd2);
        expect_head(32'h100, {32'hBBBB0001, 32'hAAAA0001}, 2'b11);
        @(negedge clk);
        chk("push1_id_valid", 64'(id_valid), 64'd1);
        chk("push1_occ", 64'(occupancy), 64'd1);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("pop1_occ", 64'(occupancy), 64'd0);
        chk("pop1_id_valid", 64'(id_valid), 64'd0);

        // Partial issue, then clamped pop
        step();
        drive(1, 32'h200, {32'hBBBB0002, 32'hAAAA0002}, 2'b11, 2'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd1);
        expect_head(32'h200, {32'hBBBB0002, 32'hAAAA0002}, 2'b11);
        step();
        drive(0, 0, 0, 2'b00, 2'd2);
        expect_head(32'h204, {NOP, 32'hBBBB0002}, 2'b01);
        @(negedge clk);
        chk("partial_occ", 64'(occupancy), 64'd1);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("partial_pop_occ", 64'(occupancy), 64'd0);

        // PC wraps modulo 2^32 on partial issue; n==v pops
        step();
        drive(1, 32'hFFFFFFFC, {32'hBBBB0003, 32'hAAAA0003}, 2'b11, 2'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd1);
        expect_head(32'hFFFFFFFC, {32'hBBBB0003, 32'hAAAA0003}, 2'b11);
        step();
        expect_head(32'h0, {NOP, 32'hBBBB0003}, 2'b01);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("pcwrap_occ", 64'(occupancy), 64'd0);

        // Fill to DEPTH; a fifth offer stays unaccepted even across a pop
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1, 32'h300 + 32'(16 * i), {32'hB3000000 + 32'(i), 32'hA3000000 + 32'(i)}, 2'b11, 2'd0);
        end
        step();
        drive(1, 32'h400, {32'hB4000000, 32'hA4000000}, 2'b11, 2'd0);
        @(negedge clk);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        step();
        drive(1, 32'h400, {32'hB4000000, 32'hA4000000}, 2'b11, 2'd2);
        expect_head(32'h300, {32'hB3000000, 32'hA3000000}, 2'b11);
        @(negedge clk);
        chk("full_pop_if_ready", 64'(if_ready), 64'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("after_full_pop_occ", 64'(occupancy), 64'd3);
        chk("after_full_pop_pc", 64'(id_pc), 64'h310);

        // Flush beats a same-cycle push and consume
        step();
        flush = 1'b1;
        drive(1, 32'h500, {32'hB5000000, 32'hA5000000}, 2'b11, 2'd1);
        step();
        flush = 1'b0;
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_id_valid", 64'(id_valid), 64'd0);
        chk("flush_if_ready", 64'(if_ready), 64'd1);
        step();
        @(negedge clk);
        chk("flush_no_ghost", 64'(id_valid), 64'd0);

        // Streaming across pointer wrap; packet 5 has a non-contiguous lane mask
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k < 10)
                drive(1, 32'h1000 + 32'(8 * k), {32'h0B000000 + 32'(k), 32'h0A000000 + 32'(k)},
                      (k == 5) ? 2'b10 : 2'b11, 2'd2);
            else
                drive(0, 0, 0, 2'b00, 2'd2);
            if (k >= 1) begin
                if (k - 1 == 5)
                    expect_head(32'h102C, {NOP, 32'h0B000005}, 2'b01);
                else
                    expect_head(32'h1000 + 32'(8 * (k - 1)),
                                {32'h0B000000 + 32'(k - 1), 32'h0A000000 + 32'(k - 1)}, 2'b11);
                @(negedge clk);
                chk("stream_occ", 64'(occupancy), 64'd1);
            end
        end
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("stream_end_occ", 64'(occupancy), 64'd0);

        // A packet with no valid lanes is accepted and discarded
        step();
        drive(1, 32'h600, {32'hB6000000, 32'hA6000000}, 2'b00, 2'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("empty_pkt_occ", 64'(occupancy), 64'd0);
        chk("empty_pkt_id_valid", 64'(id_valid), 64'd0);

        // Asynchronous reset mid-cycle with two packets held
        step();
        drive(1, 32'h700, {32'hB7000000, 32'hA7000000}, 2'b11, 2'd0);
        step();
        drive(1, 32'h708, {32'hB7000001, 32'hA7000001}, 2'b11, 2'd0);
        step();
        drive(0, 0, 0, 2'b00, 2'd0);
        @(negedge clk);
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_id_valid", 64'(id_valid), 64'd0);
        chk("arst_id_pc", 64'(id_pc), 64'd0);
        chk("arst_id_inst", id_inst, 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_if_ready", 64'(if_ready), 64'd1);

        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
